crop_run_sequencer: RTL and testbench

Sequencer that runs the `crop_plus_gaussian` core once per configured crop window and packs its five CNN output words into one result packet. It sits between the system controller (ap_ctrl_hs-style start/done) and the core. It holds `NUM_CROPS` crop origins in a config bank, issues one core start per crop, and collects the five single-word output streams. It forwards each run's result as a 5-beat AXI-stream packet and flags core hangs with a watchdog.

---
 rtl/crop_run_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_crop_run_sequencer.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crop_run_sequencer.sv
// Crop-window sequencer: runs the crop_plus_gaussian core once per configured origin and
// repacks its five single-word output streams into one 5-beat result packet per crop.
module crop_run_sequencer #(
   parameter int unsigned PIXEL_BIT_WIDTH = 16,
   parameter int unsigned NUM_CROPS       = 4,
   parameter int unsigned COORD_WIDTH     = 8,
   parameter int unsigned TIMEOUT_CYCLES  = 65535,
   localparam int unsigned AW = (NUM_CROPS > 1) ? $clog2(NUM_CROPS) : 1
) (
   input  logic                         ap_clk,
   input  logic                         ap_rst_n,
   input  logic                         ap_start,
   output logic                         ap_ready,
   output logic                         ap_done,
   output logic                         ap_idle,
   input  logic                         cfg_we,
   input  logic [AW-1:0]                cfg_addr,
   input  logic [COORD_WIDTH-1:0]       cfg_y,
   input  logic [COORD_WIDTH-1:0]       cfg_x,
   output logic                         core_ap_start,
   input  logic                         core_ap_done,
   output logic [COORD_WIDTH-1:0]       core_y1,
   output logic [COORD_WIDTH-1:0]       core_x1,
   input  logic [5*PIXEL_BIT_WIDTH-1:0] core_out_TDATA,
   input  logic [4:0]                   core_out_TVALID,
   output logic [4:0]                   core_out_TREADY,
   output logic [PIXEL_BIT_WIDTH-1:0]   res_TDATA,
   output logic                         res_TVALID,
   output logic                         res_TLAST,
   input  logic                         res_TREADY,
   output logic [AW-1:0]                crop_idx,
   output logic                         err_timeout
);
   localparam int unsigned W  = PIXEL_BIT_WIDTH;
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {StIdle, StLoad, StStart, StRun, StEmit, StDone} state_e;

   state_e                 state_q, state_d;
   logic [COORD_WIDTH-1:0] cfg_y_q [NUM_CROPS];
   logic [COORD_WIDTH-1:0] cfg_x_q [NUM_CROPS];
   logic [COORD_WIDTH-1:0] cur_y, cur_x;
   logic [COORD_WIDTH-1:0] y1_q, x1_q;
   logic [AW-1:0]          k_q;
   logic [W-1:0]           slot_q [5];
   logic [4:0]             slot_vld_q;
   logic                   done_q;
   logic [TW-1:0]          wd_q;
   logic [2:0]             beat_q;
   logic                   err_q;
   logic                   ready_q;

   logic [4:0]             cap;
   logic                   run_exit;
   logic                   wd_expire;
   logic                   last_crop;
   logic                   last_beat_acc;

   // Exit decision includes captures and done arriving on this very cycle.
   assign cap           = core_out_TVALID & core_out_TREADY;
   assign run_exit      = (done_q | core_ap_done) & (&(slot_vld_q | cap));
   assign wd_expire     = (wd_q == TW'(TIMEOUT_CYCLES - 1));
   assign last_crop     = (k_q == AW'(NUM_CROPS - 1));
   assign last_beat_acc = (state_q == StEmit) && res_TREADY && (beat_q == 3'd4);

   always_comb begin
      cur_y = '0;
      cur_x = '0;
      for (int i = 0; i < int'(NUM_CROPS); i++) begin
         if (k_q == AW'(i)) begin
            cur_y = cfg_y_q[i];
            cur_x = cfg_x_q[i];
         end
      end
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (ap_start) state_d = StLoad;
         StLoad:  state_d = StStart;
         StStart: state_d = StRun;
         StRun:   if (run_exit || wd_expire) state_d = StEmit;
         StEmit:  if (last_beat_acc) state_d = last_crop ? StDone : StLoad;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      ap_idle         = (state_q == StIdle);
      ap_done         = (state_q == StDone);
      ap_ready        = ready_q;
      core_ap_start   = (state_q == StStart);
      core_out_TREADY = (state_q == StRun) ? ~slot_vld_q : 5'b0;
      res_TVALID      = (state_q == StEmit);
      res_TLAST       = res_TVALID && (beat_q == 3'd4);
      res_TDATA       = '0;
      if (res_TVALID) begin
         unique case (beat_q)
            3'd0:    res_TDATA = slot_q[0];
            3'd1:    res_TDATA = slot_q[1];
            3'd2:    res_TDATA = slot_q[2];
            3'd3:    res_TDATA = slot_q[3];
            3'd4:    res_TDATA = slot_q[4];
            default: res_TDATA = '0;
         endcase
      end
      core_y1     = y1_q;
      core_x1     = x1_q;
      crop_idx    = k_q;
      err_timeout = err_q;
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         for (int i = 0; i < int'(NUM_CROPS); i++) begin
            cfg_y_q[i] <= '0;
            cfg_x_q[i] <= '0;
         end
      end else if (cfg_we && (state_q == StIdle)) begin
         for (int i = 0; i < int'(NUM_CROPS); i++) begin
            if (cfg_addr == AW'(i)) begin
               cfg_y_q[i] <= cfg_y;
               cfg_x_q[i] <= cfg_x;
            end
         end
      end
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         y1_q       <= '0;
         x1_q       <= '0;
         k_q        <= '0;
         for (int j = 0; j < 5; j++) slot_q[j] <= '0;
         slot_vld_q <= '0;
         done_q     <= 1'b0;
         wd_q       <= '0;
         beat_q     <= '0;
         err_q      <= 1'b0;
         ready_q    <= 1'b0;
      end else begin
         ready_q <= (state_q == StIdle) && ap_start;
         unique case (state_q)
            StIdle: begin
               if (ap_start) begin
                  err_q <= 1'b0;
                  k_q   <= '0;
               end
            end
            StLoad: begin
               y1_q <= cur_y;
               x1_q <= cur_x;
               // Zeroed slots double as the fill value if the watchdog fires.
               for (int j = 0; j < 5; j++) slot_q[j] <= '0;
               slot_vld_q <= '0;
               done_q     <= 1'b0;
               wd_q       <= '0;
               beat_q     <= '0;
            end
            StRun: begin
               for (int j = 0; j < 5; j++) begin
                  if (cap[j]) slot_q[j] <= core_out_TDATA[j*W +: W];
               end
               slot_vld_q <= slot_vld_q | cap;
               done_q     <= done_q | core_ap_done;
               wd_q       <= wd_q + TW'(1);
               if (wd_expire && !run_exit) err_q <= 1'b1;
            end
            StEmit: begin
               if (res_TREADY) begin
                  if (beat_q == 3'd4) begin
                     beat_q <= '0;
                     if (!last_crop) k_q <= k_q + AW'(1);
                  end else begin
                     beat_q <= beat_q + 3'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_crop_run_sequencer.sv
// Directed bench for crop_run_sequencer: table of crop origins and expected packet words,
// a scripted core model, and hand-written sequences for timeout, ignored inputs and reset.
module tb_crop_run_sequencer;
   localparam int unsigned W  = 16;
   localparam int unsigned NC = 3;
   localparam int unsigned CW = 8;
   localparam int unsigned TO = 16;
   localparam int unsigned AW = 2;

   logic            ap_clk = 1'b0;
   logic            ap_rst_n;
   logic            ap_start;
   logic            ap_ready, ap_done, ap_idle;
   logic            cfg_we;
   logic [AW-1:0]   cfg_addr;
   logic [CW-1:0]   cfg_y, cfg_x;
   logic            core_ap_start;
   logic            core_ap_done;
   logic [CW-1:0]   core_y1, core_x1;
   logic [5*W-1:0]  core_out_TDATA;
   logic [4:0]      core_out_TVALID;
   logic [4:0]      core_out_TREADY;
   logic [W-1:0]    res_TDATA;
   logic            res_TVALID, res_TLAST;
   logic            res_TREADY;
   logic [AW-1:0]   crop_idx;
   logic            err_timeout;

   always #5 ap_clk = ~ap_clk;

   crop_run_sequencer #(
      .PIXEL_BIT_WIDTH(W),
      .NUM_CROPS      (NC),
      .COORD_WIDTH    (CW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .ap_clk         (ap_clk),
      .ap_rst_n       (ap_rst_n),
      .ap_start       (ap_start),
      .ap_ready       (ap_ready),
      .ap_done        (ap_done),
      .ap_idle        (ap_idle),
      .cfg_we         (cfg_we),
      .cfg_addr       (cfg_addr),
      .cfg_y          (cfg_y),
      .cfg_x          (cfg_x),
      .core_ap_start  (core_ap_start),
      .core_ap_done   (core_ap_done),
      .core_y1        (core_y1),
      .core_x1        (core_x1),
      .core_out_TDATA (core_out_TDATA),
      .core_out_TVALID(core_out_TVALID),
      .core_out_TREADY(core_out_TREADY),
      .res_TDATA      (res_TDATA),
      .res_TVALID     (res_TVALID),
      .res_TLAST      (res_TLAST),
      .res_TREADY     (res_TREADY),
      .crop_idx       (crop_idx),
      .err_timeout    (err_timeout)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   always @(posedge ap_clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Origins written per slot and the first word of each crop's packet.
   typedef struct {
      int addr;
      int y;
      int x;
      int w0;
   } vec_t;
   vec_t tbl [NC];

   // Monitor: result beats, origins at core start, handshake pulses, hold-stability.
   logic [W-1:0]  got_data [$];
   logic          got_last [$];
   int            got_cyc  [$];
   logic [CW-1:0] org_y    [$];
   logic [CW-1:0] org_x    [$];
   int            ready_cnt = 0;
   int            done_cnt  = 0;
   int            done_cyc  = 0;
   bit            rand_ready = 1'b0;
   logic          ready_fixed = 1'b1;

   initial begin
      logic         prev_stall;
      logic [W-1:0] prev_data;
      logic         prev_last;
      prev_stall = 1'b0;
      prev_data  = '0;
      prev_last  = 1'b0;
      res_TREADY = 1'b1;
      forever begin
         @(negedge ap_clk);
         if (prev_stall && ap_rst_n) begin
            check("hold_valid", res_TVALID, 1);
            check("hold_data", res_TDATA, prev_data);
            check("hold_last", res_TLAST, prev_last);
         end
         res_TREADY = rand_ready ? 1'($urandom_range(0, 1)) : ready_fixed;
         if (res_TVALID && res_TREADY) begin
            got_data.push_back(res_TDATA);
            got_last.push_back(res_TLAST);
            got_cyc.push_back(cyc);
         end
         if (ap_ready) ready_cnt++;
         if (ap_done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (core_ap_start) begin
            org_y.push_back(core_y1);
            org_x.push_back(core_x1);
         end
         prev_stall = ap_rst_n && res_TVALID && !res_TREADY;
         prev_data  = res_TDATA;
         prev_last  = res_TLAST;
      end
   end

   // Core model. Mode 0: all streams at once then done; 1: out-of-order with second words;
   // 2: streams 0 and 1 only, no done.
   int core_mode = 0;
   int st_cyc    = 0;
   int emit_cyc  = 0;
   int hs2_cyc   = 0;

   task automatic run_core();
      int         start_at [5];
      int         nword    [5];
      int         sent     [5];
      int         done_at;
      int         kk;
      logic [4:0] hs;
      kk     = int'(crop_idx);
      st_cyc = cyc;
      case (core_mode)
         1: begin
            start_at = '{2, 6, 10, 0, 4};
            nword    = '{2, 2, 2, 2, 2};
            done_at  = 8;
         end
         2: begin
            start_at = '{0, 0, 0, 0, 0};
            nword    = '{1, 1, 0, 0, 0};
            done_at  = -1;
         end
         default: begin
            start_at = '{3, 3, 3, 3, 3};
            nword    = '{1, 1, 1, 1, 1};
            done_at  = 6;
         end
      endcase
      sent = '{0, 0, 0, 0, 0};
      hs   = '0;
      for (int c = 0; c < 60; c++) begin
         @(negedge ap_clk);
         if (res_TVALID || !ap_rst_n) break;
         for (int j = 0; j < 5; j++) begin
            if (hs[j]) sent[j]++;
            core_out_TVALID[j] = (c >= start_at[j]) && (sent[j] < nword[j]);
            core_out_TDATA[j*W +: W] = (sent[j] == 0) ? W'(100 + 5 * kk + j) : W'(16'h0900 + j);
         end
         core_ap_done = (c == done_at);
         // Ready does not depend on valid, so this predicts the coming edge's handshakes.
         hs = core_out_TVALID & core_out_TREADY;
         if (hs[2]) hs2_cyc = cyc;
      end
      emit_cyc        = cyc;
      core_out_TVALID = '0;
      core_ap_done    = 1'b0;
   endtask

   initial begin
      core_out_TVALID = '0;
      core_out_TDATA  = '0;
      core_ap_done    = 1'b0;
      forever begin
         @(negedge ap_clk);
         if (core_ap_start && ap_rst_n) run_core();
      end
   end

   task automatic cfg_write(input int a, input int y, input int x);
      cfg_we   = 1'b1;
      cfg_addr = AW'(a);
      cfg_y    = CW'(y);
      cfg_x    = CW'(x);
      @(negedge ap_clk);
      cfg_we   = 1'b0;
   endtask

   task automatic start_job(input string tag);
      ap_start = 1'b1;
      @(negedge ap_clk);
      ap_start = 1'b0;
      check({tag, "_ap_ready"}, ap_ready, 1);
      check({tag, "_idle_low"}, ap_idle, 0);
      check({tag, "_err_clear"}, err_timeout, 0);
      check({tag, "_no_early_start"}, core_ap_start, 0);
      @(negedge ap_clk);
      check({tag, "_core_start"}, core_ap_start, 1);
   endtask

   task automatic wait_done(input string tag, input int budget);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge ap_clk);
         if (ap_done) begin
            seen = 1'b1;
            break;
         end
      end
      check({tag, "_done_seen"}, seen, 1);
      @(negedge ap_clk);
      check({tag, "_idle_after"}, ap_idle, 1);
      check({tag, "_tready_idle"}, core_out_TREADY, 0);
   endtask

   task automatic run_job(input string tag, input int mode, output int db, output int ob,
                          output int rb, output int dnb);
      core_mode = mode;
      db  = got_data.size();
      ob  = org_y.size();
      rb  = ready_cnt;
      dnb = done_cnt;
      start_job(tag);
      wait_done(tag, 600);
      check({tag, "_one_ready"}, ready_cnt - rb, 1);
      check({tag, "_one_done"}, done_cnt - dnb, 1);
   endtask

   task automatic verify_job(input string tag, input int db, input int ob, input int mode,
                             input bit zero_org);
      int idx;
      check({tag, "_beats"}, got_data.size() - db, 15);
      check({tag, "_origins"}, org_y.size() - ob, NC);
      for (int k = 0; k < int'(NC); k++) begin
         if (ob + k < org_y.size()) begin
            check($sformatf("%s_y1_c%0d", tag, k), org_y[ob+k], zero_org ? 0 : tbl[k].y);
            check($sformatf("%s_x1_c%0d", tag, k), org_x[ob+k], zero_org ? 0 : tbl[k].x);
         end
         for (int b = 0; b < 5; b++) begin
            idx = db + 5 * k + b;
            if (idx < got_data.size()) begin
               check($sformatf("%s_data_c%0d_b%0d", tag, k, b), got_data[idx],
                     (mode == 2 && b >= 2) ? 0 : tbl[k].w0 + b);
               check($sformatf("%s_last_c%0d_b%0d", tag, k, b), got_last[idx], b == 4);
            end
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      int db, ob, rb, dnb, rdy0;

      tbl[0] = '{addr: 0, y: 10, x: 10, w0: 100};
      tbl[1] = '{addr: 1, y: 20, x: 30, w0: 105};
      tbl[2] = '{addr: 2, y: 40, x: 50, w0: 110};

      ap_rst_n = 1'b0;
      ap_start = 1'b0;
      cfg_we   = 1'b0;
      cfg_addr = '0;
      cfg_y    = '0;
      cfg_x    = '0;
      #23;
      check("rst_idle", ap_idle, 1);
      check("rst_ready", ap_ready, 0);
      check("rst_done", ap_done, 0);
      check("rst_core_start", core_ap_start, 0);
      check("rst_tready", core_out_TREADY, 0);
      check("rst_tvalid", res_TVALID, 0);
      check("rst_err", err_timeout, 0);
      check("rst_y1", core_y1, 0);
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      @(negedge ap_clk);

      // Basic job; the last config write lands the edge before the start is sampled.
      for (int k = 0; k < int'(NC); k++) cfg_write(tbl[k].addr, tbl[k].y, tbl[k].x);
      run_job("basic", 0, db, ob, rb, dnb);
      verify_job("basic", db, ob, 0, 1'b0);
      check("basic_err", err_timeout, 0);
      if (got_cyc.size() >= db + 15) begin
         check("basic_back_to_back", got_cyc[db+4] - got_cyc[db], 4);
         check("basic_done_timing", done_cyc - got_cyc[db+14], 1);
      end

      // Out-of-order capture with second words; EMIT one cycle after stream 2's handshake.
      run_job("ooo", 1, db, ob, rb, dnb);
      verify_job("ooo", db, ob, 1, 1'b0);
      check("ooo_emit_timing", emit_cyc - hs2_cyc, 1);

      // Random downstream backpressure; stability checked by the monitor.
      rand_ready = 1'b1;
      run_job("bp", 0, db, ob, rb, dnb);
      rand_ready = 1'b0;
      verify_job("bp", db, ob, 0, 1'b0);

      // Watchdog: 16 RUN cycles, then EMIT the partial packet.
      run_job("wd", 2, db, ob, rb, dnb);
      verify_job("wd", db, ob, 2, 1'b0);
      check("wd_emit_timing", emit_cyc - st_cyc, TO + 1);
      check("wd_err_set", err_timeout, 1);
      repeat (4) @(negedge ap_clk);
      check("wd_err_sticky", err_timeout, 1);

      // Start and config write during RUN must be ignored (start_job checks err clears).
      core_mode = 0;
      db   = got_data.size();
      rdy0 = ready_cnt;
      dnb  = done_cnt;
      start_job("ign");
      check("ign_err_cleared", err_timeout, 0);
      repeat (2) @(negedge ap_clk);
      ap_start = 1'b1;
      cfg_we   = 1'b1;
      cfg_addr = 2'd0;
      cfg_y    = 8'd99;
      cfg_x    = 8'd99;
      @(negedge ap_clk);
      ap_start = 1'b0;
      cfg_we   = 1'b0;
      wait_done("ign", 600);
      repeat (4) @(negedge ap_clk);
      check("ign_no_second_job", ready_cnt - rdy0, 1);
      check("ign_one_done", done_cnt - dnb, 1);
      check("ign_beats", got_data.size() - db, 15);

      // Out-of-range slot write in IDLE, then confirm the bank is untouched.
      cfg_write(3, 77, 77);
      run_job("oor", 0, db, ob, rb, dnb);
      verify_job("oor", db, ob, 0, 1'b0);

      // Reset after beat 2 of the first packet.
      core_mode = 0;
      db = got_data.size();
      start_job("rst");
      for (int i = 0; i < 200 && got_data.size() < db + 3; i++) @(negedge ap_clk);
      check("rst_reached_beat2", got_data.size() >= db + 3, 1);
      @(posedge ap_clk);
      #2;
      ap_rst_n = 1'b0;
      #1;
      check("mid_rst_idle", ap_idle, 1);
      check("mid_rst_tvalid", res_TVALID, 0);
      check("mid_rst_tlast", res_TLAST, 0);
      check("mid_rst_tdata", res_TDATA, 0);
      check("mid_rst_crop_idx", crop_idx, 0);
      check("mid_rst_y1", core_y1, 0);
      check("mid_rst_x1", core_x1, 0);
      check("mid_rst_tready", core_out_TREADY, 0);
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      @(negedge ap_clk);
      run_job("post_rst", 0, db, ob, rb, dnb);
      verify_job("post_rst", db, ob, 0, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
